// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
//   AW_DEFAULT    : default fetch PC / word-address width
//   DEPTH_DEFAULT : default prefetch FIFO depth (power of two, >= 2)
//   INSTR_W       : instruction word width
//   PC_INC        : sequential fetch step in words
//   RESET_PC      : conventional boot PC, used by benches as start_pc
package instr_fetch_unit_pkg;

  localparam int          AW_DEFAULT    = 32;
  localparam int          DEPTH_DEFAULT = 4;
  localparam int          INSTR_W       = 32;
  localparam int          PC_INC        = 1;
  localparam logic [31:0] RESET_PC      = 32'h0000_0010;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: DEPTH x DW synchronous FIFO holding {instruction, pc} pairs.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : discard all contents (priority over push)
//   push, push_data : write one entry
//   pop             : consume the head entry (ignored when empty)
//   head_valid      : FIFO not empty
//   head_data       : head entry, driven straight from the storage flops
//   count           : occupancy, 0..DEPTH
// A push is accepted together with a pop when the FIFO is full; the
// caller's credit scheme guarantees there is never a push into a full
// FIFO without a simultaneous pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;

  assign pop_ok     = pop & (count != '0);
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  // Flush only resets the pointers; stale words behind them are never
  // visible because head_valid drops with the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch front end between the PC and decode.
// Ports:
//   CLK, RESET        : clock, synchronous active-low reset
//   start_pc          : fetch PC loaded while RESET is low
//   imem_req/addr     : word-address read strobe to synchronous imem
//   imem_rdata        : read data, valid one cycle after imem_req
//   instr_valid/ready : handshake to decode (see below)
//   instr, instr_pc   : head instruction and its word address
//   redirect_valid    : single-cycle restart request (jump/taken branch)
//   redirect_target   : absolute word address to restart from
//   fifo_count        : prefetch FIFO occupancy (debug/perf)
//
// Handshake: an instruction transfers on every rising edge where
// instr_valid and instr_ready are both high. While instr_valid is high
// and instr_ready is low, instr and instr_pc hold steady. instr_ready is
// ignored while instr_valid is low. Decode may not withdraw a presented
// instruction; only a redirect or reset removes it.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [AW-1:0]          start_pc,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_W-1:0]     instr,
  output logic [AW-1:0]          instr_pc,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_target,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [AW-1:0]  fetch_pc;
  logic [AW-1:0]  tag_pc;
  logic           inflight;
  logic           pop;
  logic           push;
  logic           kill;
  logic [CW1-1:0] credit_use;

  // Credit rule: entries held + the response already on its way - the
  // entry leaving this cycle must leave room for one more word, so a
  // push can never find the FIFO full without a matching pop.
  //
  // Kill: a redirect (or reset) drops the response arriving in the same
  // cycle. No request issues in a redirect cycle, so that is the only
  // wrong-path response that can still reach the FIFO.
  always_comb begin
    pop        = instr_valid & instr_ready;
    credit_use = CW1'(fifo_count) + CW1'(inflight) - CW1'(pop);
    imem_req   = RESET & ~redirect_valid & (credit_use < CW1'(DEPTH));
    kill       = redirect_valid | ~RESET;
    push       = inflight & ~kill;
  end

  assign imem_addr = fetch_pc;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      fetch_pc <= start_pc;
      inflight <= 1'b0;
      tag_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
    end else if (imem_req) begin
      // Word addressing; wraps silently from all-ones to zero.
      fetch_pc <= fetch_pc + AW'(PC_INC);
      inflight <= 1'b1;
      tag_pc   <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  logic [INSTR_W+AW-1:0] head_data;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (INSTR_W + AW)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({imem_rdata, tag_pc}),
    .pop        (pop),
    .head_valid (instr_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign instr    = head_data[INSTR_W+AW-1:AW];
  assign instr_pc = head_data[AW-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a 32-bit-address instance exercising reset,
// streaming, backpressure, redirects and reset-over-redirect, plus an
// 8-bit-address instance for PC wrap. Memory model returns word[i] = i.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic          RESET;
  logic [AW-1:0] start_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic [CW-1:0] fifo_count;

  // wrap instance signals (AW = 8)
  logic          w_reset;
  logic          w_req;
  logic [7:0]    w_addr;
  logic [31:0]   w_rdata = '0;
  logic          w_valid;
  logic          w_ready;
  logic [31:0]   w_instr;
  logic [7:0]    w_pc;
  logic [CW-1:0] w_count;

  instr_fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK             (clk),
    .RESET           (RESET),
    .start_pc        (start_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fifo_count      (fifo_count)
  );

  instr_fetch_unit #(.DEPTH(DEPTH), .AW(8)) dut_w (
    .CLK             (clk),
    .RESET           (w_reset),
    .start_pc        (8'hFE),
    .imem_req        (w_req),
    .imem_addr       (w_addr),
    .imem_rdata      (w_rdata),
    .instr_valid     (w_valid),
    .instr_ready     (w_ready),
    .instr           (w_instr),
    .instr_pc        (w_pc),
    .redirect_valid  (1'b0),
    .redirect_target (8'h00),
    .fifo_count      (w_count)
  );

  // synchronous instruction memories: word[i] = i
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr;
    if (w_req)    w_rdata    <= {24'h0, w_addr};
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_w_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted transfer pops one expected PC; word == PC.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [7:0]  ew;
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc 0x%0h, expected no delivery", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("instr", instr, e);
        check("instr_pc", instr_pc, e);
      end
    end
    if (w_valid === 1'b1 && w_ready === 1'b1) begin
      if (exp_w_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wrap_instr: got pc 0x%0h, expected no delivery", w_pc);
      end else begin
        ew = exp_w_q.pop_front();
        check("wrap_instr", w_instr, {24'h0, ew});
        check("wrap_pc", {24'h0, w_pc}, {24'h0, ew});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET           = 1'b0;
    w_reset         = 1'b0;
    start_pc        = RESET_PC;
    instr_ready     = 1'b1;
    w_ready         = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    repeat (2) @(posedge clk);
    mid();
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_count", {29'h0, fifo_count}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_wrap_valid", {31'h0, w_valid}, 32'h0);

    // C0: release reset
    next_cycle();
    RESET   = 1'b1;
    w_reset = 1'b1;
    for (int i = 0; i < 11; i++) exp_q.push_back(32'h10 + 32'(i));
    exp_w_q.push_back(8'hFE);
    exp_w_q.push_back(8'hFF);
    exp_w_q.push_back(8'h00);
    exp_w_q.push_back(8'h01);
    mid();
    check("c0_req", {31'h0, imem_req}, 32'h1);
    check("c0_addr", imem_addr, 32'h10);
    check("c0_valid", {31'h0, instr_valid}, 32'h0);
    check("c0_wrap_addr", {24'h0, w_addr}, 32'hFE);
    next_cycle(); mid();  // C1
    check("c1_addr", imem_addr, 32'h11);
    check("c1_valid", {31'h0, instr_valid}, 32'h0);
    next_cycle(); mid();  // C2
    check("c2_valid", {31'h0, instr_valid}, 32'h1);
    repeat (4) next_cycle();  // C6

    // backpressure for 10 cycles
    instr_ready = 1'b0;
    w_ready     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (i >= 3) begin
        check("bp_count", {29'h0, fifo_count}, 32'h4);
        check("bp_req", {31'h0, imem_req}, 32'h0);
        check("bp_head", instr, 32'h14);
        check("bp_head_pc", instr_pc, 32'h14);
      end
      next_cycle();
    end

    // C16: resume, no gaps expected
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid();
      check("resume_valid", {31'h0, instr_valid}, 32'h1);
      next_cycle();
    end

    // C22: redirect to 0x100 with 3 entries buffered and one in flight
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(i));
    mid();
    check("redir_count_before", {29'h0, fifo_count}, 32'h3);
    check("redir_req", {31'h0, imem_req}, 32'h0);
    next_cycle();  // C23
    redirect_valid = 1'b0;
    mid();
    check("redir_count_after", {29'h0, fifo_count}, 32'h0);
    check("redir_valid_after", {31'h0, instr_valid}, 32'h0);
    check("redir_req_after", {31'h0, imem_req}, 32'h1);
    check("redir_addr_after", imem_addr, 32'h100);
    next_cycle(); mid();  // C24
    check("redir_c24_valid", {31'h0, instr_valid}, 32'h0);
    next_cycle(); mid();  // C25
    check("redir_c25_valid", {31'h0, instr_valid}, 32'h1);
    repeat (5) next_cycle();  // C30

    // back-to-back redirects: 0x40 then 0x80
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h80 + 32'(i));
    mid();
    check("b2b_req0", {31'h0, imem_req}, 32'h0);
    next_cycle();  // C31
    redirect_target = 32'h80;
    mid();
    check("b2b_valid1", {31'h0, instr_valid}, 32'h0);
    check("b2b_req1", {31'h0, imem_req}, 32'h0);
    next_cycle();  // C32
    redirect_valid = 1'b0;
    mid();
    check("b2b_req2", {31'h0, imem_req}, 32'h1);
    check("b2b_addr2", imem_addr, 32'h80);
    repeat (6) next_cycle();  // C38

    // reset together with redirect
    RESET           = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    instr_ready     = 1'b0;
    mid();
    check("rr_req", {31'h0, imem_req}, 32'h0);
    next_cycle();  // C39
    redirect_valid = 1'b0;
    mid();
    check("rr_valid", {31'h0, instr_valid}, 32'h0);
    check("rr_count", {29'h0, fifo_count}, 32'h0);
    check("rr_instr", instr, 32'h0);
    check("rr_pc", instr_pc, 32'h0);
    check("rr_req2", {31'h0, imem_req}, 32'h0);
    next_cycle();  // C40
    RESET       = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + 32'(i));
    mid();
    check("rr_restart_req", {31'h0, imem_req}, 32'h1);
    check("rr_restart_addr", imem_addr, 32'h10);
    repeat (6) next_cycle();  // C46
    instr_ready = 1'b0;
    repeat (4) next_cycle();
    mid();

    check("main_queue_left", 32'(exp_q.size()), 32'h0);
    check("wrap_queue_left", 32'(exp_w_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
